mvb_frame_tx: RTL
=================

MVB_FRAME_TX -- requirements
Module: mvb_frame_tx

Interface
REQ-001 Parameter BIT_CLKS, default 16, SHALL set clk_24M cycles per bit (1.5 Mbit/s); BIT_CLKS/2 cycles per half-bit; legal values are even and >= 4.
REQ-002 clk_24M  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 tx_start  input  1  single-cycle request to send one master frame.
REQ-005 tx_data  input  16  frame payload, sampled on the accepted tx_start cycle.
REQ-006 data_out  output  1  Manchester line level; registered.
REQ-007 tx_en  output  1  driver enable; high for the whole frame; registered.
REQ-008 tx_busy  output  1  high from the accepted request until tx_done.
REQ-009 tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-010 Encoding SHALL be: data '1' = H then L; data '0' = L then H; NH = H for both halves; NL = L for both halves; each half lasts BIT_CLKS/2 cycles.
REQ-011 Frame order SHALL be: start bit '1'; delimiter NH,NL,'0',NH,NL,'0','0','0'; 16 data bits, MSB first; 8 check bits; end symbol NL. Total 34 bit times.
REQ-012 Check bits SHALL be 7 CRC bits and then 1 parity bit. CRC: polynomial x^7+x^6+x^5+x^2+1, MSB-first over the 16 data bits, register initialised to 0, result complemented. Parity bit: makes the 8 check bits even parity.
REQ-013 FSM states SHALL be IDLE, START, DELIM, DATA, CHECK, END. Transitions occur only at bit boundaries.
REQ-014 IDLE -> START on tx_start=1. tx_data is latched, the CRC is cleared, and tx_busy and tx_en go high on the next cycle.
REQ-015 START lasts 1 bit, then DELIM 8 bits, DATA 16 bits, CHECK 8 bits, END 1 bit. END -> IDLE.
REQ-016 The CRC SHALL update one bit per DATA bit. The check value SHALL be final before CHECK begins, with no extra latency.
REQ-017 Latency: if tx_start is accepted in cycle N, data_out carries the first half of the start bit in cycles N+1..N+BIT_CLKS/2, and the bit boundaries fall exactly every BIT_CLKS cycles after that.
REQ-018 On the cycle after the final END half-bit: tx_done=1 for one cycle, tx_busy=0, tx_en=0, data_out=1, state IDLE.
REQ-019 In IDLE, data_out SHALL be 1 and tx_en SHALL be 0.
REQ-020 tx_start while tx_busy=1 SHALL be ignored, with no queuing and no corruption of the frame in flight.
REQ-021 tx_start in the same cycle as tx_done=1 SHALL be ignored. A new frame is accepted no earlier than the following cycle.
REQ-022 Changes to tx_data during a frame SHALL have no effect.
REQ-023 The bit counter SHALL wrap per field and never exceed the field length. The phase counter SHALL count 0..BIT_CLKS-1 and wrap.

Reset
REQ-024 With rst=0 at a clock edge, next-cycle values SHALL be: state IDLE, data_out=1, tx_en=0, tx_busy=0, tx_done=0, all counters 0, CRC 0.
REQ-025 Reset mid-frame SHALL abort immediately. The line returns to idle (data_out=1, tx_en=0) and no tx_done is issued.
REQ-026 tx_start asserted while rst=0 SHALL be ignored.

Verification
REQ-027 Start timing, BIT_CLKS=16, tx_start at cycle 0: tx_en=1 from cycle 1; data_out=1 cycles 1-8, 0 cycles 9-16, then NH=1 cycles 17-32, NL=0 cycles 33-48.
REQ-028 Full frame, tx_data=16'hA5C3: the decoded 34 symbols match REQ-011/012 against a software CRC model. tx_done pulses at cycle 545. tx_busy is high for exactly 544 cycles.
REQ-029 Loopback: data_out feeds the existing start-check and frame-receive chain. Frames with tx_data=16'h0000, 16'hFFFF and 16'h8001 are received with matching payload and check.
REQ-030 Busy rejection: a second tx_start at cycle 100 mid-frame leaves the waveform identical to a single-frame run. tx_start in the tx_done cycle is ignored; tx_start one cycle later starts a new frame.
REQ-031 Reset abort: rst=0 at cycle 300 gives data_out=1, tx_en=0, tx_busy=0 at cycle 301, with no tx_done. The next request then produces a correct full frame.
REQ-032 Parameter: BIT_CLKS=8 gives half-bits of 4 cycles, and tx_done at cycle 273 for tx_start at cycle 0.

Source files
------------

// File: rtl/mvb_frame_tx.sv
// MVB master frame transmitter.
// Sends one 34-bit-time Manchester frame per accepted request:
// start bit, 8-symbol delimiter, 16 data bits (MSB first), 7 CRC bits plus
// an even-parity bit, and a closing NL symbol. All outputs are registered.
//
// state | meaning
// IDLE  | line held high, driver off, waiting for tx_start
// START | start bit '1'
// DELIM | delimiter NH,NL,'0',NH,NL,'0','0','0'
// DATA  | payload bits, MSB first; CRC advances as each bit begins
// CHECK | complemented CRC bits then parity bit
// END   | closing NL symbol
module mvb_frame_tx #(
    parameter int BIT_CLKS = 16
) (
    input  logic        clk_24M,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [15:0] tx_data,
    output logic        data_out,
    output logic        tx_en,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int            PW       = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CLKS - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(BIT_CLKS / 2);
    localparam logic [6:0]    CRC_POLY = 7'h65;

    typedef enum logic [2:0] {IDLE, START, DELIM, DATA, CHECK, END} state_t;
    typedef enum logic [1:0] {SYM_ZERO, SYM_ONE, SYM_NL, SYM_NH} sym_t;

    state_t        state;
    state_t        nxt_state;
    logic [PW-1:0] phase;
    logic [PW-1:0] nxt_phase;
    logic [3:0]    bit_cnt;
    logic [3:0]    nxt_bit;
    logic [15:0]   data_reg;
    logic [6:0]    crc;
    logic [6:0]    crc_upd;
    logic [7:0]    check_vec;
    logic          ph_wrap;
    logic          crc_load;
    logic          nxt_level;
    sym_t          nxt_sym;

    // Index of the last bit in each field.
    function automatic logic [3:0] field_last(input state_t s);
        case (s)
            DELIM:   return 4'd7;
            DATA:    return 4'd15;
            CHECK:   return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    // Field that follows each field in the frame.
    function automatic state_t field_next(input state_t s);
        case (s)
            START:   return DELIM;
            DELIM:   return DATA;
            DATA:    return CHECK;
            CHECK:   return END;
            default: return IDLE;
        endcase
    endfunction

    function automatic sym_t delim_sym(input logic [2:0] idx);
        case (idx)
            3'd0:    return SYM_NH;
            3'd1:    return SYM_NL;
            3'd3:    return SYM_NH;
            3'd4:    return SYM_NL;
            default: return SYM_ZERO;
        endcase
    endfunction

    function automatic logic [6:0] crc_step(input logic [6:0] c, input logic din);
        return {c[5:0], 1'b0} ^ (((din ^ c[6]) == 1'b1) ? CRC_POLY : 7'h00);
    endfunction

    // Manchester level of a symbol in its first or second half.
    function automatic logic sym_level(input sym_t s, input logic first_half);
        case (s)
            SYM_ONE:  return first_half;
            SYM_ZERO: return ~first_half;
            SYM_NH:   return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    // Frame position (field, bit, phase) for the following cycle.
    always_comb begin
        ph_wrap   = (phase == PH_LAST);
        nxt_state = state;
        nxt_phase = phase + 1'b1;
        nxt_bit   = bit_cnt;
        if (ph_wrap) begin
            nxt_phase = '0;
            if (bit_cnt == field_last(state)) begin
                nxt_bit   = '0;
                nxt_state = field_next(state);
            end else begin
                nxt_bit = bit_cnt + 1'b1;
            end
        end
    end

    // CRC advances as each data bit starts, so it is complete when CHECK begins.
    always_comb begin
        check_vec = {~crc, ^(~crc)};
        crc_load  = ph_wrap && (nxt_state == DATA);
        crc_upd   = crc_step(crc, data_reg[4'd15 - nxt_bit]);
    end

    // Symbol and line level to be driven in the following cycle.
    always_comb begin
        case (nxt_state)
            START:   nxt_sym = SYM_ONE;
            DELIM:   nxt_sym = delim_sym(nxt_bit[2:0]);
            DATA:    nxt_sym = data_reg[4'd15 - nxt_bit] ? SYM_ONE : SYM_ZERO;
            CHECK:   nxt_sym = check_vec[3'd7 - nxt_bit[2:0]] ? SYM_ONE : SYM_ZERO;
            default: nxt_sym = SYM_NL;
        endcase
        nxt_level = sym_level(nxt_sym, nxt_phase < PH_HALF);
    end

    // Frame sequencer with registered line outputs.
    always_ff @(posedge clk_24M) begin
        if (!rst) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            data_reg <= '0;
            crc      <= '0;
            data_out <= 1'b1;
            tx_en    <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    data_out <= 1'b1;
                    tx_en    <= 1'b0;
                    tx_busy  <= 1'b0;
                    phase    <= '0;
                    bit_cnt  <= '0;
                    // A request coinciding with the done pulse is dropped.
                    if (tx_start && !tx_done) begin
                        state    <= START;
                        data_reg <= tx_data;
                        crc      <= '0;
                        data_out <= 1'b1;
                        tx_en    <= 1'b1;
                        tx_busy  <= 1'b1;
                    end
                end
                default: begin
                    if (nxt_state == IDLE) begin
                        state    <= IDLE;
                        phase    <= '0;
                        bit_cnt  <= '0;
                        data_out <= 1'b1;
                        tx_en    <= 1'b0;
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                    end else begin
                        state    <= nxt_state;
                        phase    <= nxt_phase;
                        bit_cnt  <= nxt_bit;
                        data_out <= nxt_level;
                        if (crc_load) begin
                            crc <= crc_upd;
                        end
                    end
                end
            endcase
        end
    end

endmodule
